// File: rtl/caxi4interconnect_cdc_rdarb_pkg.sv
// Shared types and helpers for the CDC read-side burst-locked arbiter.
// Arbiter state encoding and the source-index width helper live here.
package caxi4interconnect_cdc_rdarb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } rdarb_state_e;

  function automatic int id_width(input int num_src);
    return (num_src <= 2) ? 1 : $clog2(num_src);
  endfunction

endpackage

// File: rtl/caxi4interconnect_cdc_rdarb_rrpick.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// wrapping modulo NUM_SRC, found by scanning a doubled request vector.
module caxi4interconnect_cdc_rdarb_rrpick #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                gntValid,
  output logic [ID_WIDTH-1:0] gntId
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [2*NUM_SRC-1:0] req_rot;
  int                   idx;

  // Rotating the doubled vector right by ptr puts source ptr at bit 0;
  // only the low NUM_SRC bits form a complete wrapped window.
  always_comb begin
    req_dbl  = {req, req};
    req_rot  = req_dbl >> ptr;
    gntValid = 1'b0;
    gntId    = '0;
    idx      = 0;
    for (int k = 2 * NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k] && (k < NUM_SRC)) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        gntValid = 1'b1;
        gntId    = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/caxi4interconnect_cdc_rdarb.sv
// Burst-locked round-robin arbiter sharing one registered beat channel among
// NUM_SRC CDC FIFO read ports; a winner keeps the grant until its last beat.
module caxi4interconnect_cdc_rdarb
  import caxi4interconnect_cdc_rdarb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = id_width(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            srcValid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] srcData,
  input  logic [NUM_SRC-1:0]            srcLast,
  output logic [NUM_SRC-1:0]            srcRe,
  output logic                          outValid,
  output logic [DATA_WIDTH-1:0]         outData,
  output logic                          outLast,
  output logic [ID_WIDTH-1:0]           outSrcId,
  input  logic                          outReady
);

  rdarb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [ID_WIDTH-1:0]   out_src_id_q, out_src_id_d;

  logic                  pick_vld;
  logic [ID_WIDTH-1:0]   pick_id;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [ID_WIDTH-1:0]   nxt_ptr;
  logic                  sel_vld;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  load;

  caxi4interconnect_cdc_rdarb_rrpick #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req      (srcValid),
    .ptr      (rr_ptr_q),
    .gntValid (pick_vld),
    .gntId    (pick_id)
  );

  // While locked the picker is ignored, so other valid sources cannot steal
  // the channel even when the locked FIFO is momentarily empty.
  always_comb begin
    gnt_id   = (state_q == ST_LOCKED) ? lock_id_q : pick_id;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_id == ID_WIDTH'(i)) begin
        sel_vld  = srcValid[i];
        sel_last = srcLast[i];
        sel_data = srcData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (state_q == ST_IDLE) sel_vld = pick_vld;
    load = sel_vld & (~out_valid_q | outReady) & ~rst;
    srcRe = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (load && (gnt_id == ID_WIDTH'(i))) srcRe[i] = 1'b1;
    end
    nxt_ptr = (int'(gnt_id) == NUM_SRC - 1) ? '0 : ID_WIDTH'(int'(gnt_id) + 1);
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_id_d    = lock_id_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_src_id_d = out_src_id_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = sel_data;
      out_last_d   = sel_last;
      out_src_id_d = gnt_id;
      if (sel_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = nxt_ptr;
      end else begin
        state_d   = ST_LOCKED;
        lock_id_d = gnt_id;
      end
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Reset abandons any in-flight burst: the lock is dropped, not resumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_id_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_id_q    <= lock_id_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_id_q <= out_src_id_d;
    end
  end

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outLast  = out_last_q;
  assign outSrcId = out_src_id_q;

endmodule

// File: doc/caxi4interconnect_cdc_rdarb.md
# caxi4interconnect_CDC_rdArb

Burst-locked round-robin arbiter that shares one downstream beat channel among NUM_SRC clock-domain-crossing FIFO read ports. It runs in the read-side clock domain. It drives each FIFO's read enable, which doubles as its ready, and registers the selected beat into a single output stage. Once a source wins, it keeps the grant until its last beat is accepted, so bursts are never interleaved.

## Interface
Parameters:
- NUM_SRC, 4: number of FIFO read ports, 2..16.
- DATA_WIDTH, 64: payload bits per beat.
- ID_WIDTH, 2: source-index width, equal to max(1, clog2(NUM_SRC)).

Ports:
- clk  input  1  single clock for the block (read-side domain).
- rst  input  1  asynchronous, active-high reset.
- srcValid  input  NUM_SRC  per-source beat available (FIFO not empty).
- srcData  input  NUM_SRC*DATA_WIDTH  per-source head beat; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- srcLast  input  NUM_SRC  per-source head beat is the last of its burst.
- srcRe  output  NUM_SRC  per-source pop strobe; one-hot or zero.
- outValid  output  1  output register holds a beat.
- outData  output  DATA_WIDTH  registered beat.
- outLast  output  1  registered last flag.
- outSrcId  output  ID_WIDTH  index of the source that supplied the beat.
- outReady  input  1  downstream accepts the beat.

## Operation
- load = srcValid[g] & (!outValid | outReady), where g is the current grant. srcRe[g] = load. All other srcRe bits are 0.
- The path from outReady to srcRe is combinational. There is no combinational path from srcValid to outValid.
- State IDLE:
  - g is the first i with srcValid[i] = 1, scanning rrPtr, rrPtr+1, … modulo NUM_SRC.
  - If no source is valid, there is no grant and srcRe = 0.
  - On load with srcLast[g] = 0: go to LOCKED and set lockId = g.
  - On load with srcLast[g] = 1: stay in IDLE and set rrPtr = (g+1) mod NUM_SRC.
  - If the grant is valid but the output is stalled (no load), the choice is re-evaluated next cycle. This is legal because nothing has been popped yet.
- State LOCKED:
  - g = lockId. Other sources are ignored even when valid.
  - On load with srcLast[lockId] = 1: go to IDLE and set rrPtr = (lockId+1) mod NUM_SRC.
  - If srcValid[lockId] = 0 (FIFO momentarily empty), stay in LOCKED and issue no pop.
- Output register, on load: outData ← srcData[g], outLast ← srcLast[g], outSrcId ← g, outValid ← 1.
- When there is no load and outReady & outValid: outValid ← 0. Data fields hold their values.
- Wrap-around: the rrPtr increment is computed modulo NUM_SRC, including for non-power-of-two NUM_SRC. For example, NUM_SRC = 3 and g = 2 gives rrPtr = 0.
- Reset (asynchronous, any time, including mid-burst):
  - Registers: state = IDLE, rrPtr = 0, lockId = 0.
  - Outputs: outValid = 0, outData = 0, outLast = 0, outSrcId = 0.
  - srcRe is forced to 0 while rst = 1.
  - An in-flight burst is abandoned and not resumed.

## Timing
- Latency is 1 cycle: the srcRe pulse at edge N produces outValid from edge N+1.
- Throughput is 1 beat per cycle with outReady held high, including across a burst boundary to a different source with no bubble.
- Handshake: a beat transfers on outValid & outReady. outData, outLast and outSrcId stay stable while outValid = 1 and outReady = 0.
- A source is popped only in a cycle where its beat is captured. No beat is ever dropped or duplicated.

## Structure
- State encodings (IDLE = 1'b0, LOCKED = 1'b1) and the ID_WIDTH helper function go in the shared caxi4interconnect include/package.
- One sub-module: caxi4interconnect_RRPick.
  - Combinational rotating-priority picker.
  - Inputs: req[NUM_SRC], ptr[ID_WIDTH].
  - Outputs: gntValid, gntId.
  - Implemented with a doubled request vector.
- The top level holds the FSM, rrPtr, lockId, the data mux and the output register.

## Test plan
- **Reset:** assert rst mid-burst with outValid = 1 → next edge shows outValid = 0, srcRe = 0 and outData = 0. After release, src0 wins first when all sources are valid.
- **Fairness:** NUM_SRC = 4, all srcValid = 1, single-beat bursts, outReady = 1 → outSrcId sequence 0,1,2,3,0,… with one beat per cycle.
- **Lock:** src1 sends a 4-beat burst while src0 and src2 are held valid → four consecutive beats with outSrcId = 1, then src2, then src0.
- **Lock gap:** src1 drops srcValid for 3 cycles mid-burst while others are valid → srcRe[0] = srcRe[2] = 0 throughout, and the burst resumes on src1.
- **Backpressure:** random outReady toggling against a scoreboard → output data, ordering and last flags match per source, with no beat lost or duplicated.
- **Wrap:** NUM_SRC = 3 with only src2 and src0 valid, single-beat bursts → the sequence alternates 2,0,2,0 and rrPtr never reaches 3.
